bcd_display_scheduler: RTL and testbench

BCD_DISPLAY_SCHEDULER -- requirements
Module: bcd_display_scheduler

---
 rtl/bcd_sched_pkg.sv | 20 ++
 rtl/bcd_converter.sv | 60 ++++++
 rtl/bcd_display_scheduler.sv | 149 ++++++++++++++
 tb/tb_bcd_display_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_sched_pkg.sv
// Shared FSM encoding and clamp helper for the BCD display scheduler.
package bcd_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_STORE
  } state_t;

  function automatic int max_dec(input int digits);
    int v;
    v = 1;
    for (int i = 0; i < digits; i++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

endpackage

// File: rtl/bcd_converter.sv
// Sequential double-dabble binary to BCD converter.
// One bit per cycle; o_DV pulses INPUT_WIDTH cycles after i_Start.
module bcd_converter #(
  parameter int INPUT_WIDTH    = 8,
  parameter int DECIMAL_DIGITS = 3
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset,
  input  logic                        i_Start,
  input  logic [INPUT_WIDTH-1:0]      i_Binary,
  output logic [DECIMAL_DIGITS*4-1:0] o_BCD,
  output logic                        o_DV
);

  localparam int BW = DECIMAL_DIGITS * 4;
  localparam int CW = $clog2(INPUT_WIDTH + 1);

  logic [INPUT_WIDTH-1:0] bin_q;
  logic [BW-1:0]          bcd_q;
  logic [BW-1:0]          bcd_adj;
  logic [CW-1:0]          cnt_q;
  logic                   busy_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < DECIMAL_DIGITS; d++) begin
      if (bcd_q[d*4 +: 4] >= 4'd5) begin
        bcd_adj[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      o_BCD  <= '0;
      o_DV   <= 1'b0;
    end else begin
      o_DV <= 1'b0;
      if (i_Start) begin
        bin_q  <= i_Binary;
        bcd_q  <= '0;
        cnt_q  <= CW'(INPUT_WIDTH);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
        cnt_q          <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          o_DV   <= 1'b1;
          o_BCD  <= {bcd_adj[BW-2:0], bin_q[INPUT_WIDTH-1]};
        end
      end
    end
  end

endmodule

// File: rtl/bcd_display_scheduler.sv
// Round-robin scheduler sharing one BCD converter among display channels.
// Optional WAIT watchdog enabled by defining BCD_SCHED_TIMEOUT_EN.
module bcd_display_scheduler
  import bcd_sched_pkg::*;
#(
  parameter int NUM_CH         = 3,
  parameter int INPUT_WIDTH    = 8,
  parameter int DECIMAL_DIGITS = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                               i_Clock,
  input  logic                               i_Reset,
  input  logic [NUM_CH-1:0]                  i_Req,
  input  logic [NUM_CH*INPUT_WIDTH-1:0]      i_Binary,
  output logic [NUM_CH-1:0]                  o_Ack,
  output logic [NUM_CH*DECIMAL_DIGITS*4-1:0] o_BCD,
  output logic [NUM_CH-1:0]                  o_Valid,
  output logic                               o_Busy,
  output logic                               o_Error
);

  localparam int BW      = DECIMAL_DIGITS * 4;
  localparam int GW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MAX_DEC = max_dec(DECIMAL_DIGITS);
  localparam logic [INPUT_WIDTH-1:0] MAX_W = INPUT_WIDTH'(MAX_DEC);

  state_t                 state_q, state_d;
  logic [GW-1:0]          grant_q, last_q, pick;
  logic                   pick_ok;
  logic [INPUT_WIDTH-1:0] pick_val, clamped, snap_q;
  logic [BW-1:0]          cap_q, conv_bcd;
  logic                   conv_start, conv_dv, timeout;

  // First requester strictly after last_q, wrapping.
  always_comb begin
    pick_ok = 1'b0;
    pick    = last_q;
    for (int i = 1; i <= NUM_CH; i++) begin
      int idx;
      idx = int'(last_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!pick_ok && i_Req[idx]) begin
        pick_ok = 1'b1;
        pick    = GW'(idx);
      end
    end
  end

  always_comb begin
    pick_val = i_Binary[int'(pick)*INPUT_WIDTH +: INPUT_WIDTH];
    clamped  = pick_val;
    if (int'(pick_val) > MAX_DEC) clamped = MAX_W;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pick_ok) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (conv_dv)      state_d = S_STORE;
        else if (timeout) state_d = S_IDLE;
      end
      S_STORE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    conv_start = (state_q == S_START);
    o_Busy     = (state_q != S_IDLE);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      grant_q <= '0;
      last_q  <= GW'(NUM_CH - 1);
      snap_q  <= '0;
      cap_q   <= '0;
      o_BCD   <= '0;
      o_Valid <= '0;
      o_Ack   <= '0;
    end else begin
      o_Ack <= '0;
      if (state_q == S_IDLE && pick_ok) begin
        grant_q <= pick;
        snap_q  <= clamped;
      end
      if (state_q == S_WAIT && conv_dv) cap_q <= conv_bcd;
      if (state_q == S_STORE) begin
        o_BCD[int'(grant_q)*BW +: BW] <= cap_q;
        o_Valid[grant_q]              <= 1'b1;
        o_Ack[grant_q]                <= 1'b1;
        last_q                        <= grant_q;
      end
      // Abandoned conversion still acknowledges, result untouched.
      if (timeout) begin
        o_Ack[grant_q] <= 1'b1;
        last_q         <= grant_q;
      end
    end
  end

`ifdef BCD_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wcnt_q;
  logic          err_q;

  assign timeout = (state_q == S_WAIT) && !conv_dv &&
                   (wcnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q != S_WAIT) wcnt_q <= '0;
      else if (!timeout)     wcnt_q <= wcnt_q + TW'(1);
      if (timeout) err_q <= 1'b1;
    end
  end

  assign o_Error = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
  assign o_Error        = 1'b0;
`endif

  bcd_converter #(
    .INPUT_WIDTH   (INPUT_WIDTH),
    .DECIMAL_DIGITS(DECIMAL_DIGITS)
  ) u_conv (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Start (conv_start),
    .i_Binary(snap_q),
    .o_BCD   (conv_bcd),
    .o_DV    (conv_dv)
  );

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Scoreboard bench for bcd_display_scheduler (10-bit inputs, 3 digits).
// Expectations follow BCD_SCHED_TIMEOUT_EN when it is defined.
module tb_bcd_display_scheduler;

  localparam int NC = 3;
  localparam int IW = 10;
  localparam int DD = 3;
  localparam int BW = DD * 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NC-1:0]      req = '0;
  logic [NC*IW-1:0]   bin = '0;
  logic [NC-1:0]      ack;
  logic [NC*BW-1:0]   bcd;
  logic [NC-1:0]      valid;
  logic               busy;
  logic               err;

  typedef struct {
    int          ch;
    logic [11:0] bcd;
  } exp_t;

  exp_t          q[$];
  logic [NC*BW-1:0] sh_bcd   = '0;
  logic [NC-1:0]    sh_valid = '0;
  logic             sh_err   = 1'b0;
  int checks = 0;
  int errors = 0;

  bcd_display_scheduler #(
    .NUM_CH        (NC),
    .INPUT_WIDTH   (IW),
    .DECIMAL_DIGITS(DD),
    .TIMEOUT_CYCLES(2)
  ) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .i_Req   (req),
    .i_Binary(bin),
    .o_Ack   (ack),
    .o_BCD   (bcd),
    .o_Valid (valid),
    .o_Busy  (busy),
    .o_Error (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic expect_ack(input int ch, input logic [11:0] v);
    exp_t e;
    e.ch  = ch;
    e.bcd = v;
    q.push_back(e);
  endtask

  task automatic set_val(input int ch, input int v);
    bin[ch*IW +: IW] = IW'(v);
  endtask

  // Monitor: every ack pops one expectation
  always @(negedge clk) begin
    if (!rst && ack != '0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack act=%b exp=none", ack);
      end else begin
        exp_t e;
        logic [NC-1:0] ea;
        e  = q.pop_front();
        ea = NC'(1) << e.ch;
`ifdef BCD_SCHED_TIMEOUT_EN
        sh_err = 1'b1;
`else
        sh_bcd[e.ch*BW +: BW] = e.bcd;
        sh_valid[e.ch]        = 1'b1;
`endif
        chk("ack_onehot", ack, ea);
        chk("bcd_bus", bcd, sh_bcd);
        chk("valid", valid, sh_valid);
        chk("error", err, sh_err);
      end
    end
  end

  task automatic wait_acks(input int n, input bit drop);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) begin
        got += $countones(ack);
        if (drop) req = req & ~ack;
      end
    end
    if (got < n) chk("ack_timeout", 64'(got), 64'(n));
  endtask

  task automatic wait_busy();
    int cyc = 0;
    @(negedge clk);
    while (!busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("busy_seen", busy, 1'b1);
  endtask

  task automatic clear_model();
    q.delete();
    sh_bcd   = '0;
    sh_valid = '0;
    sh_err   = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack"}, ack, '0);
    chk({tag, "_bcd"}, bcd, '0);
    chk({tag, "_valid"}, valid, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_error"}, err, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    req = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset("rst0");

    // single channel
    set_val(0, 23);
    expect_ack(0, 12'h023);
    #1 req = 3'b001;
    wait_acks(1, 1);

    // held requests rotate from channel 0
    do_reset("rst1");
    set_val(0, 5);
    set_val(1, 67);
    set_val(2, 255);
    expect_ack(0, 12'h005);
    expect_ack(1, 12'h067);
    expect_ack(2, 12'h255);
    expect_ack(0, 12'h005);
    req = 3'b111;
    wait_acks(4, 0);
    req = '0;

    // clamp of out-of-range value
    set_val(1, 1023);
    expect_ack(1, 12'h999);
    req = 3'b010;
    wait_acks(1, 1);

    // clamp boundary; last grant ch1 so ch2 wins
    set_val(0, 1000);
    set_val(2, 999);
    expect_ack(2, 12'h999);
    expect_ack(0, 12'h999);
    req = 3'b101;
    wait_acks(2, 1);

    // request dropped after grant, input changed
    set_val(0, 42);
    expect_ack(0, 12'h042);
    req = 3'b001;
    wait_busy();
    req = '0;
    set_val(0, 7);
    wait_acks(1, 0);

    // reset during WAIT of ch2
    set_val(2, 77);
    req = 3'b100;
    wait_busy();
    @(posedge clk);
    #1 rst = 1'b1;
    req = '0;
    clear_model();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("midwait");
    repeat (20) @(negedge clk);

    // channel 0 first after reset
    set_val(0, 1);
    set_val(1, 2);
    set_val(2, 3);
    expect_ack(0, 12'h001);
    expect_ack(1, 12'h002);
    expect_ack(2, 12'h003);
    req = 3'b111;
    wait_acks(3, 1);
    repeat (5) @(negedge clk);

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
